// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: address field layout,
// stored-tag bit positions, controller state encoding and a saturating
// increment helper used by the statistics counters.
package dcache_pkg;

  // Address layout: tag [31:9], index [8:5], word [4:2], byte [1:0]
  localparam int WORD_W     = 32;
  localparam int WORD_SEL_W = 3;
  localparam int OFF_W      = 5;
  localparam int WORD_LSB   = 2;
  localparam int IDX_LSB    = 5;
  localparam int TAG_LSB    = 9;

  // Stored tag is {valid, dirty, tag}
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_OK
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational word access on a cache line.
// Ports:
//   line     in  LINE_W  source cache line
//   word_sel in  3       selected 32-bit word within the line
//   wdata    in  32      word to insert
//   rdata    out 32      selected word extracted from line
//   merged   out LINE_W  line with the selected word replaced by wdata
module dcache_word_merge
  import dcache_pkg::*;
#(
  parameter int LINE_W = 256
) (
  input  logic [LINE_W-1:0]     line,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata,
  output logic [LINE_W-1:0]     merged
);

  localparam int N_WORDS = LINE_W / WORD_W;

  logic [WORD_W-1:0] words [N_WORDS];

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
    assign words[gi] = line[gi*WORD_W +: WORD_W];
    assign merged[gi*WORD_W +: WORD_W] =
      (word_sel == WORD_SEL_W'(gi)) ? wdata : line[gi*WORD_W +: WORD_W];
  end

  assign rdata = words[word_sel];

endmodule

// File: rtl/dcache_controller.sv
// Data-cache controller for a 2-way, 16-set cache in front of a 256-bit
// line memory. Hits are served in the lookup cycle; a miss stalls the CPU
// while the dirty victim (if any) is written back and the line is refilled,
// after which the stalled access replays as a hit.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   cpu_*   : CPU word access (req/write/addr/data in, data/stall out)
//   sram_*  : tag/data SRAM access (addr/tag/data/enable/write out,
//             selected-way tag/data and hit in)
//   mem_*   : line memory (enable/write/addr/data out, data/ack in)
//   hit_cnt_o, miss_cnt_o : saturating statistics counters
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [TAG_W+1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [TAG_W+1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  unused_byte_bits;

  assign req_tag          = cpu_addr_i[TAG_LSB +: TAG_W];
  assign req_idx          = cpu_addr_i[IDX_LSB +: IDX_W];
  assign req_word         = cpu_addr_i[WORD_LSB +: WORD_SEL_W];
  assign unused_byte_bits = ^cpu_addr_i[WORD_LSB-1:0];

  state_t              state_reg;
  logic                mem_enable_reg;
  logic                mem_write_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [TAG_W+1:0]    victim_tag_reg;
  logic [LINE_W-1:0]   victim_line_reg;
  logic [LINE_W-1:0]   refill_line_reg;
  logic [TAG_W-1:0]    cpu_tag_reg;
  logic [IDX_W-1:0]    cpu_idx_reg;
  logic [31:0]         hit_cnt_reg;
  logic [31:0]         miss_cnt_reg;

  logic                lookup_hit;
  logic                lookup_miss;
  logic                victim_dirty;
  logic [31:0]         read_word;
  logic [LINE_W-1:0]   store_line;

  assign lookup_hit   = (state_reg == S_IDLE) & cpu_req_i & sram_hit_i;
  assign lookup_miss  = (state_reg == S_IDLE) & cpu_req_i & ~sram_hit_i;
  assign victim_dirty = victim_tag_reg[VALID_BIT] & victim_tag_reg[DIRTY_BIT];

  dcache_word_merge #(
    .LINE_W (LINE_W)
  ) u_word_merge (
    .line     (sram_data_i),
    .word_sel (req_word),
    .wdata    (cpu_data_i),
    .rdata    (read_word),
    .merged   (store_line)
  );

  // SRAM side and stall are combinational so a hit completes in its lookup
  // cycle. Outside IDLE the SRAM sees the latched miss address.
  always_comb begin
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = cpu_idx_reg;
    sram_tag_o    = {1'b1, 1'b0, cpu_tag_reg};
    sram_data_o   = refill_line_reg;
    cpu_stall_o   = 1'b1;
    cpu_data_o    = read_word;
    case (state_reg)
      S_IDLE: begin
        sram_enable_o = cpu_req_i;
        sram_write_o  = lookup_hit & cpu_write_i;
        sram_addr_o   = req_idx;
        // Tag is driven independent of the hit result to keep the SRAM
        // compare path free of combinational feedback.
        sram_tag_o    = {1'b1, cpu_write_i, req_tag};
        sram_data_o   = store_line;
        cpu_stall_o   = lookup_miss;
      end
      S_REFILL_OK: begin
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg       <= S_IDLE;
      mem_enable_reg  <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      victim_tag_reg  <= '0;
      victim_line_reg <= '0;
      refill_line_reg <= '0;
      cpu_tag_reg     <= '0;
      cpu_idx_reg     <= '0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt_reg <= sat_inc(hit_cnt_reg);
      end
      case (state_reg)
        S_IDLE: begin
          if (lookup_miss) begin
            victim_tag_reg  <= sram_tag_i;
            victim_line_reg <= sram_data_i;
            cpu_tag_reg     <= req_tag;
            cpu_idx_reg     <= req_idx;
            miss_cnt_reg    <= sat_inc(miss_cnt_reg);
            state_reg       <= S_MISS;
          end
        end
        S_MISS: begin
          mem_enable_reg <= 1'b1;
          if (victim_dirty) begin
            mem_write_reg <= 1'b1;
            mem_addr_reg  <= {victim_tag_reg[TAG_W-1:0], cpu_idx_reg, {OFF_W{1'b0}}};
            state_reg     <= S_WRITEBACK;
          end else begin
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= {cpu_tag_reg, cpu_idx_reg, {OFF_W{1'b0}}};
            state_reg     <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          // Request stays up across the switch to the refill read.
          if (mem_ack_i) begin
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= {cpu_tag_reg, cpu_idx_reg, {OFF_W{1'b0}}};
            state_reg     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            refill_line_reg <= mem_data_i;
            mem_enable_reg  <= 1'b0;
            state_reg       <= S_REFILL_OK;
          end
        end
        S_REFILL_OK: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_data_o   = victim_line_reg;
  assign hit_cnt_o    = hit_cnt_reg;
  assign miss_cnt_o   = miss_cnt_reg;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural 2-way SRAM, scoreboarded line
// memory responder, directed CPU access sequence.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CPU-visible memory contents and backing memory contents.
  logic [31:0]  ref_words [logic [31:0]];
  logic [255:0] mem_model [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_words.exists(a) ? ref_words[a] : init_word(a);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] la);
    logic [255:0] ln;
    for (int i = 0; i < 8; i++) ln[i*32 +: 32] = ref_word(la + 32'(4*i));
    return ln;
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] la);
    logic [255:0] ln;
    if (mem_model.exists(la)) return mem_model[la];
    for (int i = 0; i < 8; i++) ln[i*32 +: 32] = init_word(la + 32'(4*i));
    return ln;
  endfunction

  // Behavioural 2-way SRAM: hit refreshes LRU, fill writes the LRU way.
  logic         sram_init;
  logic [24:0]  tagmem  [0:1][0:15];
  logic [255:0] datamem [0:1][0:15];
  logic         lru     [0:15];
  logic         hw0, hw1, sel;

  always_comb begin
    hw0 = tagmem[0][sram_addr_o][24] && (tagmem[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
    hw1 = tagmem[1][sram_addr_o][24] && (tagmem[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
    sram_hit_i  = hw0 | hw1;
    sel         = hw0 ? 1'b0 : (hw1 ? 1'b1 : lru[sram_addr_o]);
    sram_tag_i  = tagmem[sel][sram_addr_o];
    sram_data_i = datamem[sel][sram_addr_o];
  end

  always @(posedge clk_i) begin
    if (sram_init) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          tagmem[w][s]  <= '0;
          datamem[w][s] <= '0;
        end
      for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
    end else if (sram_enable_o) begin
      if (sram_hit_i) begin
        if (sram_write_o) begin
          tagmem[sel][sram_addr_o]  <= sram_tag_o;
          datamem[sel][sram_addr_o] <= sram_data_o;
        end
        lru[sram_addr_o] <= ~sel;
      end else if (sram_write_o) begin
        tagmem[lru[sram_addr_o]][sram_addr_o]  <= sram_tag_o;
        datamem[lru[sram_addr_o]][sram_addr_o] <= sram_data_o;
        lru[sram_addr_o] <= ~lru[sram_addr_o];
      end
    end
  end

  // Memory responder checking each request against the expected queue.
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           lat;
  } mem_txn_t;

  mem_txn_t mem_exp_q [$];
  logic     resp_en = 1'b1;
  logic     ack_resp = 1'b0;
  logic     ack_force = 1'b0;
  int       wait_cnt = 0;

  assign mem_ack_i = ack_resp | ack_force;

  always @(negedge clk_i) begin
    mem_txn_t t;
    int lat;
    ack_resp = 1'b0;
    if (!resp_en || !mem_enable_o) begin
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      lat = (mem_exp_q.size() > 0) ? mem_exp_q[0].lat : 1;
      if (wait_cnt >= lat) begin
        wait_cnt = 0;
        ack_resp = 1'b1;
        check("mem_req_expected", (mem_exp_q.size() != 0), 1'b1);
        if (mem_exp_q.size() != 0) begin
          t = mem_exp_q.pop_front();
          $display("mem txn wr=%0d addr=%08h", mem_write_o, mem_addr_o);
          check("mem_write", mem_write_o, t.wr);
          check("mem_addr", mem_addr_o, t.addr);
          if (t.wr) begin
            check("mem_wb_line", mem_data_o, t.data);
            mem_model[mem_addr_o] = mem_data_o;
          end else begin
            mem_data_i = mem_read(mem_addr_o);
          end
        end
      end
    end
  end

  logic [31:0] exp_hit, exp_miss;
  logic [31:0] load_q [$];

  task automatic push_mem(input logic wr, input logic [31:0] addr, input int lat);
    mem_txn_t t;
    t.wr = wr; t.addr = addr; t.lat = lat;
    t.data = wr ? exp_line(addr) : '0;
    mem_exp_q.push_back(t);
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_stall, input string tag);
    int stalls = 0;
    bit done = 0;
    logic [255:0] ln;
    logic [31:0] exp_word;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
    if (!wr) load_q.push_back(ref_word(addr));
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!cpu_stall_o) begin
        done = 1;
        if (!wr) begin
          exp_word = load_q.pop_front();
          check({tag, " load_data"}, cpu_data_o, exp_word);
        end else begin
          ln = exp_line({addr[31:5], 5'b0});
          ln[addr[4:2]*32 +: 32] = wdata;
          check({tag, " store_strobes"}, {sram_enable_o, sram_write_o}, 2'b11);
          check({tag, " store_tag"}, sram_tag_o, {2'b11, addr[31:9]});
          check({tag, " store_line"}, sram_data_o, ln);
          ref_words[{addr[31:2], 2'b00}] = wdata;
        end
        exp_hit = (exp_hit == 32'hFFFF_FFFF) ? exp_hit : exp_hit + 32'd1;
      end else begin
        stalls++;
        if (sram_enable_o && sram_write_o)
          check({tag, " refill_tag"}, sram_tag_o, {2'b10, addr[31:9]});
        @(negedge clk_i);
      end
    end
    check({tag, " completed"}, done, 1'b1);
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    if (exp_stall > 0) exp_miss = exp_miss + 32'd1;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    #1;
    check({tag, " hit_cnt"}, hit_cnt_o, exp_hit);
    check({tag, " miss_cnt"}, miss_cnt_o, exp_miss);
    check({tag, " mem_queue_empty"}, 32'(mem_exp_q.size()), 32'd0);
    $display("access %s wr=%0d addr=%08h stalls=%0d", tag, wr, addr, stalls);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_i = 1'b0; sram_init = 1'b1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_data_i = '0;
    exp_hit = '0; exp_miss = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1; sram_init = 1'b0;
    #1;
    check("reset stall", cpu_stall_o, 1'b0);
    check("reset mem_enable", mem_enable_o, 1'b0);
    check("reset mem_write", mem_write_o, 1'b0);
    check("reset sram_enable", sram_enable_o, 1'b0);
    check("reset hit_cnt", hit_cnt_o, 32'd0);
    check("reset miss_cnt", miss_cnt_o, 32'd0);

    // Cold miss, clean refill of set 2.
    push_mem(1'b0, 32'h0000_0040, 5);
    access(1'b0, 32'h0000_0040, 32'h0, 8, "A cold_load");
    // Store hit marks the line dirty.
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, "B store_hit");
    // Second tag into the empty way.
    push_mem(1'b0, 32'h0000_0240, 3);
    access(1'b0, 32'h0000_0240, 32'h0, 6, "C second_way");
    // Third tag evicts the dirty LRU line.
    push_mem(1'b1, 32'h0000_0040, 4);
    push_mem(1'b0, 32'h0000_0440, 2);
    access(1'b0, 32'h0000_0440, 32'h0, 9, "D dirty_evict");
    // Clean victim, refill returns the written-back data.
    push_mem(1'b0, 32'h0000_0040, 2);
    access(1'b0, 32'h0000_0044, 32'h0, 5, "E clean_evict");
    access(1'b0, 32'h0000_005C, 32'h0, 0, "F load_hit_w7");
    access(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 0, "G1 store_hit");
    access(1'b0, 32'h0000_0440, 32'h0, 0, "G2 load_hit");

    // Reset in the middle of a write-back.
    resp_en = 1'b0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0240;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (mem_enable_o) seen = 1;
      else @(negedge clk_i);
    end
    check("H wb_started", seen, 1'b1);
    check("H wb_write", mem_write_o, 1'b1);
    check("H wb_addr", mem_addr_o, 32'h0000_0040);
    check("H wb_line", mem_data_o, exp_line(32'h0000_0040));
    @(negedge clk_i);
    rst_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("H rst mem_enable", mem_enable_o, 1'b0);
    check("H rst mem_write", mem_write_o, 1'b0);
    check("H rst stall", cpu_stall_o, 1'b0);
    check("H rst hit_cnt", hit_cnt_o, 32'd0);
    check("H rst miss_cnt", miss_cnt_o, 32'd0);
    exp_hit = '0; exp_miss = '0;
    ack_force = 1'b1;
    @(negedge clk_i);
    ack_force = 1'b0;
    #1;
    check("H late_ack mem_enable", mem_enable_o, 1'b0);
    check("H late_ack stall", cpu_stall_o, 1'b0);
    check("H late_ack sram_enable", sram_enable_o, 1'b0);
    $display("reset during write-back applied");
    resp_en = 1'b1;
    access(1'b0, 32'h0000_0044, 32'h0, 0, "I hit_after_reset");

    // Hit counter saturation.
    @(negedge clk_i);
    force dut.hit_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_reg;
    exp_hit = 32'hFFFF_FFFE;
    access(1'b0, 32'h0000_0050, 32'h0, 0, "J sat_reach");
    access(1'b0, 32'h0000_0044, 32'h0, 0, "K sat_hold");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
